freq_ramp_ctrl: RTL and testbench

Sequencer between the UART command receiver and the 3-phase sine/PWM datapath. It accepts a target electrical frequency code and steps the live frequency code toward it at a fixed rate, one LSB per ramp tick. It gates PWM enable so the motor always soft-starts from `FREQ_START` and soft-stops to zero. Its `freq` output drives the frequency divider and V/f voltage scaler directly, replacing the raw UART byte.

---
 rtl/freq_ramp_ctrl.sv | 179 +++++++++++++++++
 tb/tb_freq_ramp_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_ramp_ctrl.sv
// Frequency ramp sequencer: soft-starts, ramps and soft-stops the live frequency code for the PWM datapath.
// Optional fault latch is built in when FREQ_RAMP_FAULT_EN is defined.
module freq_ramp_ctrl #(
  parameter int unsigned RAMP_DIV   = 500000,
  parameter logic [7:0]  FREQ_MAX   = 8'd200,
  parameter logic [7:0]  FREQ_START = 8'd1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_freq,
  input  logic       estop,
`ifdef FREQ_RAMP_FAULT_EN
  input  logic       fault_in,
  input  logic       fault_clr,
  output logic       fault,
`endif
  output logic [7:0] freq,
  output logic       pwm_en,
  output logic       busy,
  output logic       at_target,
  output logic [1:0] state
);

  localparam int unsigned   CW       = $clog2(RAMP_DIV);
  localparam logic [CW-1:0] TICK_VAL = CW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_RUN   = 2'd2,
    ST_DECEL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    freq_q, freq_d;
  logic [7:0]    target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_en_q, pwm_en_d;
  logic          busy_q, busy_d;
  logic          at_target_q, at_target_d;

  logic          tick;
  logic          force_stop;
  logic          cmd_ok;
  logic [7:0]    cmd_target;
  logic [7:0]    dec_floor;

  // cmd_valid is a one-cycle strobe with no ready: every strobe is taken
  // unless a forced stop (or a latched fault) is active in that cycle.
`ifdef FREQ_RAMP_FAULT_EN
  logic fault_q, fault_d;

  assign force_stop = estop | fault_in;
  assign cmd_ok     = cmd_valid & ~force_stop & ~fault_q;
  assign fault      = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (fault_in)       fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
  end
`else
  assign force_stop = estop;
  assign cmd_ok     = cmd_valid & ~estop;
`endif

  assign tick      = (cnt_q == TICK_VAL);
  assign dec_floor = (target_q > FREQ_START) ? target_q : FREQ_START;

  always_comb begin
    cmd_target = cmd_freq;
    if (cmd_freq == 8'h00 || cmd_freq == 8'hFF) cmd_target = 8'h00;
    else if (cmd_freq > FREQ_MAX)               cmd_target = FREQ_MAX;
    else if (cmd_freq < FREQ_START)             cmd_target = FREQ_START;
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    pwm_en_d = pwm_en_q;

    if (force_stop) begin
      state_d  = ST_IDLE;
      freq_d   = 8'd0;
      target_d = 8'd0;
      cnt_d    = '0;
      pwm_en_d = 1'b0;
    end else begin
      if (cmd_ok) target_d = cmd_target;

      // Direction decisions use the registered target, so a command that
      // lands on a tick only takes effect on the following cycle.
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (target_q != 8'd0) begin
            state_d  = ST_ACCEL;
            freq_d   = FREQ_START;
            pwm_en_d = 1'b1;
          end
        end
        ST_ACCEL: begin
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (target_q < freq_q) begin
            state_d = ST_DECEL;
          end else if (target_q == freq_q) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (tick) begin
            freq_d = freq_q + 8'd1;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (target_q > freq_q)      state_d = ST_ACCEL;
          else if (target_q < freq_q) state_d = ST_DECEL;
        end
        ST_DECEL: begin
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (target_q > freq_q) begin
            state_d = ST_ACCEL;
          end else if (target_q != 8'd0 && target_q == freq_q) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (tick) begin
            if (freq_q > dec_floor) begin
              freq_d = freq_q - 8'd1;
            end else if (target_q == 8'd0) begin
              state_d  = ST_IDLE;
              freq_d   = 8'd0;
              pwm_en_d = 1'b0;
              cnt_d    = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d      = (state_d == ST_ACCEL) || (state_d == ST_DECEL);
    at_target_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      freq_q      <= 8'd0;
      target_q    <= 8'd0;
      cnt_q       <= '0;
      pwm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b0;
`ifdef FREQ_RAMP_FAULT_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      pwm_en_q    <= pwm_en_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
`ifdef FREQ_RAMP_FAULT_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign freq      = freq_q;
  assign pwm_en    = pwm_en_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;
  assign state     = state_q;

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Scoreboard bench for freq_ramp_ctrl: every output change is matched, with its cycle gap, against an expected queue.
// Fault-latch scenario runs only when FREQ_RAMP_FAULT_EN is defined.
module tb_freq_ramp_ctrl;

  localparam int         RAMP_DIV = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEL  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DECEL  = 2'd3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_freq = 8'd0;
  logic       estop = 1'b0;
  logic [7:0] freq;
  logic       pwm_en, busy, at_target;
  logic [1:0] state;
`ifdef FREQ_RAMP_FAULT_EN
  logic       fault_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault;
`endif

  int checks = 0;
  int fails  = 0;

  // Entry: {gap[7:0], freq[7:0], pwm_en, busy, at_target, state[1:0]}
  logic [20:0] exp_q[$];
  logic [12:0] prev_obs = '0;
  int          cyc_since = 0;

  freq_ramp_ctrl #(
    .RAMP_DIV  (RAMP_DIV),
    .FREQ_MAX  (8'd200),
    .FREQ_START(8'd1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cmd_valid(cmd_valid),
    .cmd_freq (cmd_freq),
    .estop    (estop),
`ifdef FREQ_RAMP_FAULT_EN
    .fault_in (fault_in),
    .fault_clr(fault_clr),
    .fault    (fault),
`endif
    .freq     (freq),
    .pwm_en   (pwm_en),
    .busy     (busy),
    .at_target(at_target),
    .state    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- expectation model ----------------
  function automatic logic [20:0] ev(input int gap, input logic [7:0] f, input logic [1:0] st);
    logic p, b, a;
    p = (st != S_IDLE);
    b = (st == S_ACCEL) || (st == S_DECEL);
    a = (st == S_RUN);
    return {8'(gap), f, p, b, a, st};
  endfunction

  task automatic push(input int gap, input logic [7:0] f, input logic [1:0] st);
    exp_q.push_back(ev(gap, f, st));
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [12:0] cur_obs;
  logic [20:0] exp_e;
  logic        ref_evt;

  always @(negedge clk) begin
    if (resetn) begin
      cyc_since = cyc_since + 1;
      cur_obs = {freq, pwm_en, busy, at_target, state};
      if (cur_obs !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got gap=%0d freq=%0d pwm=%0b busy=%0b at=%0b st=%0d, required no change",
                   cyc_since, freq, pwm_en, busy, at_target, state);
        end else begin
          exp_e = exp_q.pop_front();
          if (exp_e !== {8'(cyc_since), cur_obs}) begin
            fails++;
            $display("FAIL event: got gap=%0d freq=%0d pwm=%0b busy=%0b at=%0b st=%0d, required gap=%0d freq=%0d pwm=%0b busy=%0b at=%0b st=%0d",
                     cyc_since, freq, pwm_en, busy, at_target, state,
                     exp_e[20:13], exp_e[12:5], exp_e[4], exp_e[3], exp_e[2], exp_e[1:0]);
          end
        end
        prev_obs  = cur_obs;
        cyc_since = 0;
      end
      ref_evt = cmd_valid | estop;
`ifdef FREQ_RAMP_FAULT_EN
      ref_evt = ref_evt | fault_in;
`endif
      if (ref_evt) cyc_since = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_freq  = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic estop_pulse();
    @(posedge clk); #1;
    estop = 1'b1;
    @(posedge clk); #1;
    estop = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_freq"}, int'(freq), 0);
    check({name, "_pwm_en"}, int'(pwm_en), 0);
    check({name, "_state"}, int'(state), int'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_freq", int'(freq), 0);
    check("reset_pwm_en", int'(pwm_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_at_target", int'(at_target), 0);
    check("reset_state", int'(state), int'(S_IDLE));

    // Soft start to 5
    push(2, 8'd1, S_ACCEL);
    for (int f = 2; f <= 5; f++) push(4, 8'(f), S_ACCEL);
    push(1, 8'd5, S_RUN);
    send_cmd(8'd5);
    drain("soft_start", 200);

    // Soft stop via 8'hFF
    push(2, 8'd5, S_DECEL);
    for (int f = 4; f >= 1; f--) push(4, 8'(f), S_DECEL);
    push(4, 8'd0, S_IDLE);
    send_cmd(8'hFF);
    drain("soft_stop", 200);

    // Reversal: ACCEL toward 10, cmd 3 issued in the cycle freq becomes 6
    push(2, 8'd1, S_ACCEL);
    for (int f = 2; f <= 6; f++) push(4, 8'(f), S_ACCEL);
    push(2, 8'd6, S_DECEL);
    push(2, 8'd5, S_DECEL);
    push(4, 8'd4, S_DECEL);
    push(4, 8'd3, S_DECEL);
    push(1, 8'd3, S_RUN);
    send_cmd(8'd10);
    repeat (20) @(posedge clk);
    send_cmd(8'd3);
    drain("reversal", 200);

    // Stop with 8'h00 from RUN at 3
    push(2, 8'd3, S_DECEL);
    push(4, 8'd2, S_DECEL);
    push(4, 8'd1, S_DECEL);
    push(4, 8'd0, S_IDLE);
    send_cmd(8'h00);
    drain("stop_00", 200);

    // 8'h00 while IDLE changes nothing
    send_cmd(8'h00);
    repeat (10) @(posedge clk);
    check_idle("idle_00");

    // Clamp: 250 ramps up to 200, then estop drops to 0
    push(2, 8'd1, S_ACCEL);
    for (int f = 2; f <= 200; f++) push(4, 8'(f), S_ACCEL);
    push(1, 8'd200, S_RUN);
    send_cmd(8'd250);
    drain("clamp", 1200);
    push(1, 8'd0, S_IDLE);
    estop_pulse();
    drain("clamp_estop", 20);

    // estop at freq 7 during ACCEL, with a command issued while held
    push(2, 8'd1, S_ACCEL);
    for (int f = 2; f <= 7; f++) push(4, 8'(f), S_ACCEL);
    push(1, 8'd0, S_IDLE);
    send_cmd(8'd20);
    repeat (25) @(posedge clk);
    @(posedge clk); #1 estop = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_freq = 8'd9;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 estop = 1'b0;
    repeat (12) @(posedge clk);
    check_idle("estop_hold");
    drain("estop", 20);

`ifdef FREQ_RAMP_FAULT_EN
    push(2, 8'd1, S_ACCEL);
    for (int f = 2; f <= 4; f++) push(4, 8'(f), S_ACCEL);
    push(1, 8'd4, S_RUN);
    send_cmd(8'd4);
    drain("fault_start", 200);

    push(1, 8'd0, S_IDLE);
    @(posedge clk); #1 fault_in = 1'b1;
    @(posedge clk); #1 fault_in = 1'b0;
    @(negedge clk);
    check("fault_set", int'(fault), 1);
    send_cmd(8'd5);
    repeat (10) @(posedge clk);
    check_idle("fault_cmd_ignored");
    check("fault_sticky", int'(fault), 1);

    @(posedge clk); #1 fault_in = 1'b1; fault_clr = 1'b1;
    @(posedge clk); #1 fault_in = 1'b0; fault_clr = 1'b0;
    @(negedge clk);
    check("fault_clr_blocked", int'(fault), 1);

    @(posedge clk); #1 fault_clr = 1'b1;
    @(posedge clk); #1 fault_clr = 1'b0;
    @(negedge clk);
    check("fault_cleared", int'(fault), 0);

    push(2, 8'd1, S_ACCEL);
    push(4, 8'd2, S_ACCEL);
    push(4, 8'd3, S_ACCEL);
    push(1, 8'd3, S_RUN);
    send_cmd(8'd3);
    drain("fault_restart", 200);
    push(1, 8'd0, S_IDLE);
    estop_pulse();
    drain("fault_end", 20);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
